// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter controller: FSM states and PC step.
package pc_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ISR = 1'b1
  } pc_state_e;

  localparam int unsigned PC_STEP = 4;

endpackage : pc_pkg

// File: rtl/pc_reg.sv
// Program-counter register: XLEN-wide, loads i_d when enabled, resets to RESET_VEC.
module pc_reg #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_VEC = '0
) (
  input  logic            i_clk,
  input  logic            in_rst,
  input  logic            i_en,
  input  logic [XLEN-1:0] i_d,
  output logic [XLEN-1:0] o_q
);

  // NOTE: reset sits in the sensitivity list so the PC clears without a clock edge.
  always_ff @(posedge i_clk or negedge in_rst) begin
    if (!in_rst) begin
      o_q <= RESET_VEC;
    end else if (i_en) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      o_q <= i_d;
    end
  end

endmodule : pc_reg

// File: rtl/pc_ctrl.sv
// PC sequencing with branch redirect and a single-level interrupt handler state.
// Optional build macro: PC_VECTORED_IRQ_EN selects trap target TRAP_VEC + 4*i_cause.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_VEC = '0,
  parameter logic [XLEN-1:0]  TRAP_VEC  = 'h100,
  parameter int unsigned      CAUSE_W   = 4
) (
  input  logic               i_clk,
  input  logic               in_rst,
  input  logic               i_stall,
  input  logic               i_br_taken,
  input  logic [XLEN-1:0]    i_br_target,
  input  logic               i_irq,
  input  logic [CAUSE_W-1:0] i_cause,
  input  logic               i_mret,
  output logic [XLEN-1:0]    o_pc,
  output logic [XLEN-1:0]    o_epc,
  output logic               o_irq_ack,
  output logic               o_in_isr
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] next_normal;
  logic [XLEN-1:0] trap_pc;
  logic            epc_load;

  assign seq_pc      = o_pc + XLEN'(PC_STEP);
  assign next_normal = i_br_taken ? i_br_target : seq_pc;

`ifdef PC_VECTORED_IRQ_EN
  assign trap_pc = TRAP_VEC + (XLEN'(i_cause) << 2);
`else
  logic unused_cause;
  assign unused_cause = ^i_cause;
  assign trap_pc      = TRAP_VEC;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_d  = state_q;
    pc_d     = next_normal;
    epc_load = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (i_irq) begin
          pc_d     = trap_pc;
          epc_load = 1'b1;
          state_d  = ST_ISR;
        end
      end
      ST_ISR: begin
        if (i_mret) begin
          pc_d    = epc_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Ack is gated by reset and stall so it never pulses while state is frozen.
  assign o_irq_ack = in_rst & ~i_stall & epc_load;

  always_ff @(posedge i_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q <= ST_RUN;
      epc_q   <= '0;
    end else if (!i_stall) begin
      state_q <= state_d;
      if (epc_load) begin
        epc_q <= next_normal;
      end
    end
  end

  pc_reg #(
    .XLEN      (XLEN),
    .RESET_VEC (RESET_VEC)
  ) u_pc_reg (
    .i_clk  (i_clk),
    .in_rst (in_rst),
    .i_en   (~i_stall),
    .i_d    (pc_d),
    .o_q    (o_pc)
  );

  assign o_epc    = epc_q;
  assign o_in_isr = (state_q == ST_ISR);

endmodule : pc_ctrl

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl; vectored expectations follow PC_VECTORED_IRQ_EN.
module tb_pc_ctrl;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CAUSE_W = 4;

  logic               i_clk = 1'b0;
  logic               in_rst;
  logic               i_stall;
  logic               i_br_taken;
  logic [XLEN-1:0]    i_br_target;
  logic               i_irq;
  logic [CAUSE_W-1:0] i_cause;
  logic               i_mret;
  logic [XLEN-1:0]    o_pc;
  logic [XLEN-1:0]    o_epc;
  logic               o_irq_ack;
  logic               o_in_isr;

  int checks = 0;
  int errors = 0;

`ifdef PC_VECTORED_IRQ_EN
  localparam logic [XLEN-1:0] TRAP_C3 = 32'h10C;
`else
  localparam logic [XLEN-1:0] TRAP_C3 = 32'h100;
`endif

  pc_ctrl #(
    .XLEN      (XLEN),
    .RESET_VEC (32'h0),
    .TRAP_VEC  (32'h100),
    .CAUSE_W   (CAUSE_W)
  ) dut (
    .i_clk       (i_clk),
    .in_rst      (in_rst),
    .i_stall     (i_stall),
    .i_br_taken  (i_br_taken),
    .i_br_target (i_br_target),
    .i_irq       (i_irq),
    .i_cause     (i_cause),
    .i_mret      (i_mret),
    .o_pc        (o_pc),
    .o_epc       (o_epc),
    .o_irq_ack   (o_irq_ack),
    .o_in_isr    (o_in_isr)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_stall     = 1'b0;
    i_br_taken  = 1'b0;
    i_br_target = '0;
    i_irq       = 1'b0;
    i_cause     = '0;
    i_mret      = 1'b0;
  endtask

  // Pulse reset away from clock edges, then run two free cycles so o_pc = 8.
  task automatic reset_to_8();
    idle_inputs();
    in_rst = 1'b0;
    #2;
    in_rst = 1'b1;
    tick();
    tick();
    checks++;
    if (o_pc !== 32'h8) begin
      errors++;
      $display("FAIL setup_pc8: o_pc got %h expected %h", o_pc, 32'h8);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    in_rst = 1'b0;
    #3;
    checks++;
    if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", o_pc); end
    checks++;
    if (o_epc !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h expected 0", o_epc); end
    checks++;
    if (o_in_isr !== 1'b0) begin errors++; $display("FAIL reset_in_isr: got %b expected 0", o_in_isr); end
    checks++;
    if (o_irq_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", o_irq_ack); end
    @(negedge i_clk);
    in_rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (o_pc !== XLEN'(4 * i)) begin
        errors++;
        $display("FAIL free_run_%0d: o_pc got %h expected %h", i, o_pc, XLEN'(4 * i));
      end
    end
  endtask

  task automatic test_branch();
    reset_to_8();
    i_br_taken  = 1'b1;
    i_br_target = 32'h40;
    tick();
    checks++;
    if (o_pc !== 32'h40) begin errors++; $display("FAIL branch_taken: o_pc got %h expected 40", o_pc); end
    i_br_taken = 1'b0;
    tick();
    checks++;
    if (o_pc !== 32'h44) begin errors++; $display("FAIL branch_seq: o_pc got %h expected 44", o_pc); end
    i_mret = 1'b1;
    tick();
    checks++;
    if (o_pc !== 32'h48 || o_in_isr !== 1'b0) begin
      errors++;
      $display("FAIL mret_in_run: o_pc %h in_isr %b expected 48 0", o_pc, o_in_isr);
    end
    i_mret = 1'b0;
  endtask

  task automatic test_irq_branch();
    reset_to_8();
    i_irq       = 1'b1;
    i_br_taken  = 1'b1;
    i_br_target = 32'h40;
    i_cause     = 4'd3;
    #1;
    checks++;
    if (o_irq_ack !== 1'b1) begin errors++; $display("FAIL irq_ack_pulse: got %b expected 1", o_irq_ack); end
    tick();
    checks++;
    if (o_pc !== TRAP_C3) begin errors++; $display("FAIL irq_trap_pc: got %h expected %h", o_pc, TRAP_C3); end
    checks++;
    if (o_epc !== 32'h40) begin errors++; $display("FAIL irq_epc: got %h expected 40", o_epc); end
    checks++;
    if (o_in_isr !== 1'b1) begin errors++; $display("FAIL irq_in_isr: got %b expected 1", o_in_isr); end
    checks++;
    if (o_irq_ack !== 1'b0) begin errors++; $display("FAIL irq_ack_one_cycle: got %b expected 0", o_irq_ack); end
    idle_inputs();
    tick();
    checks++;
    if (o_pc !== TRAP_C3 + 32'h4) begin
      errors++;
      $display("FAIL isr_seq: o_pc got %h expected %h", o_pc, TRAP_C3 + 32'h4);
    end
  endtask

  task automatic test_stall_nesting();
    reset_to_8();
    i_stall = 1'b1;
    i_irq   = 1'b1;
    #1;
    checks++;
    if (o_irq_ack !== 1'b0) begin errors++; $display("FAIL stall_no_ack: got %b expected 0", o_irq_ack); end
    tick();
    checks++;
    if (o_pc !== 32'h8 || o_in_isr !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold: o_pc %h in_isr %b expected 8 0", o_pc, o_in_isr);
    end
    i_stall = 1'b0;
    tick();
    checks++;
    if (o_pc !== 32'h100 || o_epc !== 32'hC || o_in_isr !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_entry: o_pc %h epc %h in_isr %b expected 100 c 1", o_pc, o_epc, o_in_isr);
    end
    checks++;
    if (o_irq_ack !== 1'b0) begin errors++; $display("FAIL no_nest_ack: got %b expected 0", o_irq_ack); end
    tick();
    checks++;
    if (o_pc !== 32'h104 || o_epc !== 32'hC || o_in_isr !== 1'b1) begin
      errors++;
      $display("FAIL no_nest: o_pc %h epc %h in_isr %b expected 104 c 1", o_pc, o_epc, o_in_isr);
    end
    i_stall = 1'b1;
    i_mret  = 1'b1;
    tick();
    checks++;
    if (o_pc !== 32'h104 || o_in_isr !== 1'b1) begin
      errors++;
      $display("FAIL stall_mret_hold: o_pc %h in_isr %b expected 104 1", o_pc, o_in_isr);
    end
    i_stall     = 1'b0;
    i_br_taken  = 1'b1;
    i_br_target = 32'h80;
    tick();
    checks++;
    if (o_pc !== 32'hC || o_in_isr !== 1'b0) begin
      errors++;
      $display("FAIL mret_return: o_pc %h in_isr %b expected c 0", o_pc, o_in_isr);
    end
    i_mret     = 1'b0;
    i_br_taken = 1'b0;
    #1;
    checks++;
    if (o_irq_ack !== 1'b1) begin errors++; $display("FAIL reentry_ack: got %b expected 1", o_irq_ack); end
    tick();
    checks++;
    if (o_pc !== 32'h100 || o_epc !== 32'h10 || o_in_isr !== 1'b1) begin
      errors++;
      $display("FAIL reentry: o_pc %h epc %h in_isr %b expected 100 10 1", o_pc, o_epc, o_in_isr);
    end
    i_irq = 1'b0;
  endtask

  task automatic test_wrap_isr_reset();
    reset_to_8();
    i_br_taken  = 1'b1;
    i_br_target = 32'hFFFF_FFFC;
    tick();
    checks++;
    if (o_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup: o_pc got %h expected fffffffc", o_pc); end
    i_br_taken = 1'b0;
    tick();
    checks++;
    if (o_pc !== 32'h0) begin errors++; $display("FAIL wrap: o_pc got %h expected 0", o_pc); end
    i_irq = 1'b1;
    tick();
    i_irq = 1'b0;
    checks++;
    if (o_in_isr !== 1'b1 || o_epc !== 32'h4) begin
      errors++;
      $display("FAIL wrap_irq: in_isr %b epc %h expected 1 4", o_in_isr, o_epc);
    end
    #2;
    in_rst = 1'b0;
    i_irq  = 1'b1;
    #1;
    checks++;
    if (o_pc !== 32'h0 || o_in_isr !== 1'b0 || o_epc !== 32'h0) begin
      errors++;
      $display("FAIL isr_async_reset: o_pc %h in_isr %b epc %h expected 0 0 0", o_pc, o_in_isr, o_epc);
    end
    checks++;
    if (o_irq_ack !== 1'b0) begin errors++; $display("FAIL reset_irq_ack: got %b expected 0", o_irq_ack); end
    i_irq = 1'b0;
    #1;
    in_rst = 1'b1;
    tick();
    checks++;
    if (o_pc !== 32'h4) begin errors++; $display("FAIL post_reset_run: o_pc got %h expected 4", o_pc); end
  endtask

  initial begin
    idle_inputs();
    in_rst = 1'b1;
    test_reset();
    test_branch();
    test_irq_branch();
    test_stall_nesting();
    test_wrap_isr_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pc_ctrl

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC/address width.
REQ-002 SHALL have parameter RESET_VEC, default 0: PC value after reset.
REQ-003 SHALL have parameter TRAP_VEC, default 'h100: interrupt handler base address.
REQ-004 SHALL have parameter CAUSE_W, default 4: interrupt cause width.
REQ-005 SHALL have port i_clk  in  1  clock, rising edge.
REQ-006 SHALL have port in_rst  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have port i_stall  in  1  hold PC and all state.
REQ-008 SHALL have port i_br_taken  in  1  redirect to i_br_target.
REQ-009 SHALL have port i_br_target  in  XLEN  branch/jump target.
REQ-010 SHALL have port i_irq  in  1  level interrupt request.
REQ-011 SHALL have port i_cause  in  CAUSE_W  interrupt cause, sampled with i_irq.
REQ-012 SHALL have port i_mret  in  1  return from handler.
REQ-013 SHALL have port o_pc  out  XLEN  current fetch PC.
REQ-014 SHALL have port o_epc  out  XLEN  saved return PC.
REQ-015 SHALL have port o_irq_ack  out  1  one-cycle pulse on handler entry.
REQ-016 SHALL have port o_in_isr  out  1  high while in handler state.

Function
REQ-017 SHALL compute seq_pc = o_pc + 4, modulo 2^XLEN (wrap from all-ones-minus-3 to 0).
REQ-018 SHALL compute next-normal = i_br_taken ? i_br_target : seq_pc.
REQ-019 SHALL implement two states: RUN (o_in_isr=0) and ISR (o_in_isr=1).
REQ-020 SHALL, when i_stall=1, hold o_pc, o_epc and state, and keep o_irq_ack low, regardless of other inputs.
REQ-021 SHALL, in RUN with i_irq=1 and i_stall=0: load o_pc with the trap target, load o_epc with next-normal, pulse o_irq_ack for that cycle, enter ISR.
REQ-022 SHALL, in RUN with i_irq=0, load o_pc with next-normal; i_mret in RUN is ignored.
REQ-023 SHALL, in ISR with i_mret=1 and i_stall=0: load o_pc with o_epc, return to RUN; i_br_taken in the same cycle is ignored.
REQ-024 SHALL, in ISR without i_mret, load o_pc with next-normal; i_irq is ignored (no nesting) and stays pending until RUN.
REQ-025 SHALL give priority: reset > stall > irq entry (RUN) / mret (ISR) > branch > sequential.
REQ-026 SHALL allow i_irq still high in the cycle after mret to re-enter ISR, with o_epc = next-normal of that cycle.
REQ-027 SHALL register all outputs except o_irq_ack, which is combinational from the entry condition; PC update latency is one cycle.

Reset
REQ-028 SHALL, on in_rst low, immediately set o_pc=RESET_VEC, o_epc=0, state=RUN (o_in_isr=0), o_irq_ack=0, including mid-handler.
REQ-029 SHALL resume RUN sequencing on the first rising edge after in_rst deasserts.

Configuration
REQ-030 SHALL, with PC_VECTORED_IRQ_EN defined, use trap target = TRAP_VEC + 4*i_cause (zero-extended, modulo 2^XLEN).
REQ-031 SHALL, without PC_VECTORED_IRQ_EN, use trap target = TRAP_VEC and ignore i_cause.

Structure
REQ-032 SHALL take the state enum (RUN, ISR) and the instruction step constant (4) from a shared package pc_pkg.
REQ-033 SHALL keep the PC register as a sub-module pc_reg (XLEN-wide, async active-low reset to RESET_VEC, enable input); everything else stays in pc_ctrl.

Verification
REQ-034 SHALL cover reset then 3 free cycles: o_pc = 0, 4, 8, 12.
REQ-035 SHALL cover branch: o_pc=8, i_br_taken=1, target 'h40 -> next o_pc='h40, then 'h44.
REQ-036 SHALL cover irq with branch: o_pc=8, i_irq=1, i_br_taken=1, target 'h40 -> o_pc='h100, o_epc='h40, o_irq_ack=1 for one cycle, o_in_isr=1; vectored build with i_cause=3 -> o_pc='h10C.
REQ-037 SHALL cover stall and nesting: i_stall=1 with i_irq=1 -> o_pc held, no ack; in ISR i_irq=1 -> no re-entry; i_mret=1 -> o_pc=o_epc, o_in_isr=0.
REQ-038 SHALL cover wrap and mid-ISR reset: o_pc='hFFFF_FFFC -> next 0; in_rst low in ISR -> o_pc=0, o_in_isr=0 with no clock edge.
